group_normalizer_seq: RTL

- Iterative left-normalizer for the MAC datapath: the consumer end of the group zero-detection scheme.
- Accepts an unnormalized mantissa and shifts it left until its MSB is 1, returning the shifted mantissa and the leading-zero count.
- Coarse phase shifts by one group (GLEN bits) per cycle while the top group is all zeros; fine phase then shifts 1 bit per cycle.
- valid/ready handshake on input and output; sits between the adder tree and the rounding stage.

---
 rtl/group_normalizer_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/group_normalizer_seq.sv
// Iterative left-normalizer: coarse group-wide shifts while the top group is zero,
// then single-bit shifts until the MSB is set. valid/ready on both sides.
module group_normalizer_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GLEN  = 2,
    parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [CW-1:0]    out_shift_o,
    output logic             out_zero_o
);

    typedef enum logic [1:0] {StIdle, StCoarse, StFine, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        count_d = count_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    count_d = '0;
                    data_d  = in_data_i;
                    // Zero input is diverted here so the coarse loop always terminates.
                    if (in_data_i == '0) begin
                        zero_d  = 1'b1;
                        count_d = CW'(WIDTH);
                        state_d = StDone;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = StCoarse;
                    end
                end
            end
            StCoarse: begin
                if (data_q[WIDTH-1 -: GLEN] == '0) begin
                    data_d  = data_q << GLEN;
                    count_d = count_q + CW'(GLEN);
                end else if (data_q[WIDTH-1]) begin
                    state_d = StDone;
                end else begin
                    data_d  = data_q << 1;
                    count_d = count_q + CW'(1);
                    state_d = StFine;
                end
            end
            StFine: begin
                if (data_q[WIDTH-1]) begin
                    state_d = StDone;
                end else begin
                    data_d  = data_q << 1;
                    count_d = count_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_data_o  = data_q;
    assign out_shift_o = count_q;
    assign out_zero_o  = zero_q;

endmodule
